// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches INSTS_PER_FETCH instructions per APB-style
// read, buffers them in a DEPTH-entry FIFO and presents one instruction per cycle
// with its PC. Supports redirect/flush and unaligned redirect targets.
module prefetch_queue #(
  parameter int unsigned INST_W          = 16,
  parameter int unsigned INSTS_PER_FETCH = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              redirect,
  input  logic [ADDR_W-1:0]                 redirect_pc,
  input  logic                              stall,
  output logic                              psel,
  output logic                              penable,
  output logic [ADDR_W-1:0]                 paddr,
  input  logic [INST_W*INSTS_PER_FETCH-1:0] prdata,
  input  logic                              pready,
  output logic [INST_W-1:0]                 inst,
  output logic [ADDR_W-1:0]                 inst_pc,
  output logic                              inst_valid,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int unsigned N  = INSTS_PER_FETCH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(N - 1);

  // Encoding chosen so psel/penable come straight from the state flops.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b10;
  localparam logic [1:0] ST_ACCESS = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [SW-1:0]     skip_q, skip_d;
  logic              drop_q, drop_d;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_d;
  logic [CW-1:0]     push_n;
  logic              push_c;
  logic              pop_c;
  logic              xfer_done;
  logic              space_ok;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]     lane_idx [N];
  logic              lane_en  [N];

  assign psel       = state_q[1];
  assign penable    = state_q[0];
  assign inst       = mem_inst[rd_ptr_q];
  assign inst_pc    = mem_pc[rd_ptr_q];
  assign inst_valid = (count != '0);

  // Next-state, fetch tracking, drop flag and occupancy update.
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr;
    fetch_pc_d = fetch_pc_q;
    skip_d     = skip_q;
    drop_d     = drop_q;
    push_c     = 1'b0;
    push_n     = '0;

    xfer_done = (state_q == ST_ACCESS) && pready;
    pop_c     = inst_valid && !stall && !redirect;

    if (xfer_done && !drop_q && !redirect) begin
      push_c     = 1'b1;
      push_n     = CW'(N) - CW'(skip_q);
      fetch_pc_d = paddr + ADDR_W'(N);
      skip_d     = '0;
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      skip_d     = SW'(redirect_pc & ~ALIGN_MASK);
    end

    // A redirect only needs a drop if the bus transfer outlives this edge.
    if (redirect && ((state_q == ST_SETUP) || ((state_q == ST_ACCESS) && !pready))) begin
      drop_d = 1'b1;
    end else if (xfer_done) begin
      drop_d = 1'b0;
    end

    // Room for a full fetch word, counting this push but not this pop.
    space_ok = (count + push_n) <= CW'(DEPTH - N);

    case (state_q)
      ST_IDLE:   if (!redirect && space_ok) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready) state_d = space_ok ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      paddr_d = fetch_pc_d & ALIGN_MASK;
    end

    if (redirect) begin
      count_d = '0;
    end else begin
      count_d = count + push_n - CW'(pop_c);
    end
  end

  // Queue slot for each fetched lane; leading skipped lanes are not written.
  always_comb begin
    for (int unsigned l = 0; l < N; l++) begin
      lane_en[l]  = push_c && (SW'(l) >= skip_q);
      lane_idx[l] = wr_ptr_q + PW'(l) - PW'(skip_q);
    end
  end

  // Control state, bus address, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      paddr      <= '0;
      fetch_pc_q <= '0;
      skip_q     <= '0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count      <= '0;
    end else begin
      state_q    <= state_d;
      paddr      <= paddr_d;
      fetch_pc_q <= fetch_pc_d;
      skip_q     <= skip_d;
      drop_q     <= drop_d;
      count      <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
        wr_ptr_q <= wr_ptr_q + PW'(push_n);
      end
    end
  end

  // Instruction/PC storage; lane 0 sits in the most significant bits of prdata.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < N; l++) begin
      if (lane_en[l]) begin
        mem_inst[lane_idx[l]] <= prdata[(N-1-l)*INST_W +: INST_W];
        mem_pc[lane_idx[l]]   <= paddr + ADDR_W'(l);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue (INST_W=16, N=2, DEPTH=8, ADDR_W=32).
module tb_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic [31:0] prdata;
  logic        pready;
  logic [15:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder controls.
  logic const_data  = 1'b1;
  logic manual_mode = 1'b0;
  logic ready_man   = 1'b0;
  int   ready_delay = 0;
  logic ready_auto  = 1'b0;
  int   acc_cyc     = 0;

  // Bus monitor results.
  logic [31:0] setup_addrs[$];
  int          n_xfers = 0;

  prefetch_queue #(
    .INST_W(16), .INSTS_PER_FETCH(2), .DEPTH(8), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .psel(psel), .penable(penable), .paddr(paddr),
    .prdata(prdata), .pready(pready), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] inst_of(input logic [31:0] a);
    return a[15:0] + 16'h1000;
  endfunction

  assign prdata = const_data ? 32'hAAAA_BBBB : {inst_of(paddr), inst_of(paddr + 32'd1)};
  assign pready = manual_mode ? ready_man : ready_auto;

  // Auto responder: raise pready after ready_delay waiting cycles in ACCESS.
  always @(negedge clk) begin
    if (psel === 1'b1 && penable === 1'b1) begin
      ready_auto = (acc_cyc >= ready_delay);
      acc_cyc    = acc_cyc + 1;
    end else begin
      ready_auto = 1'b0;
      acc_cyc    = 0;
    end
  end

  // Record SETUP addresses and completed transfers.
  always @(posedge clk) begin
    if (rst === 1'b1 && psel === 1'b1 && penable === 1'b0) setup_addrs.push_back(paddr);
    if (rst === 1'b1 && psel === 1'b1 && penable === 1'b1 && pready === 1'b1) n_xfers = n_xfers + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait: 0 = SETUP, 1 = ACCESS, 2 = inst_valid.
  task automatic wait_for(input string tag, input int what, input int max_cyc);
    int  k;
    logic hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < max_cyc) begin
      case (what)
        0:       hit = (psel === 1'b1 && penable === 1'b0);
        1:       hit = (psel === 1'b1 && penable === 1'b1);
        default: hit = (inst_valid === 1'b1);
      endcase
      if (!hit) begin
        @(negedge clk);
        k++;
      end
    end
    check_eq(tag, 64'(hit), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] setup_at(input int idx);
    if (idx < setup_addrs.size()) return setup_addrs[idx];
    return 32'hxxxx_xxxx;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sbase;
    int xbase;

    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

    // 1. Reset behaviour and first fetches.
    tick(3);
    check_eq("rst_psel", 64'(psel), 64'd0);
    check_eq("rst_penable", 64'(penable), 64'd0);
    check_eq("rst_paddr", 64'(paddr), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_valid", 64'(inst_valid), 64'd0);
    rst = 1'b1;
    sbase = setup_addrs.size();
    tick(1);
    check_eq("t1_setup_psel", 64'(psel), 64'd1);
    check_eq("t1_setup_penable", 64'(penable), 64'd0);
    check_eq("t1_setup_paddr", 64'(paddr), 64'd0);
    tick(1);
    check_eq("t1_access_penable", 64'(penable), 64'd1);
    tick(1);
    check_eq("t1_head0_inst", 64'(inst), 64'hAAAA);
    check_eq("t1_head0_pc", 64'(inst_pc), 64'd0);
    tick(1);
    check_eq("t1_head1_inst", 64'(inst), 64'hBBBB);
    check_eq("t1_head1_pc", 64'(inst_pc), 64'd1);
    tick(4);
    check_eq("t1_paddr_seq0", 64'(setup_at(sbase)), 64'd0);
    check_eq("t1_paddr_seq1", 64'(setup_at(sbase + 1)), 64'd2);
    check_eq("t1_paddr_seq2", 64'(setup_at(sbase + 2)), 64'd4);

    // 2. Fill with stall held, then pop one and two entries.
    const_data = 1'b0;
    stall = 1'b1;
    do_reset();
    xbase = n_xfers;
    tick(14);
    check_eq("t2_xfers", 64'(n_xfers - xbase), 64'd4);
    check_eq("t2_count_full", 64'(count), 64'd8);
    check_eq("t2_psel_full", 64'(psel), 64'd0);
    check_eq("t2_head_inst", 64'(inst), 64'h1000);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    check_eq("t2_count7", 64'(count), 64'd7);
    check_eq("t2_psel_c7", 64'(psel), 64'd0);
    tick(1);
    check_eq("t2_psel_c7_hold", 64'(psel), 64'd0);
    check_eq("t2_head_pc1", 64'(inst_pc), 64'd1);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    check_eq("t2_count6", 64'(count), 64'd6);
    tick(1);
    check_eq("t2_setup_psel", 64'(psel), 64'd1);
    check_eq("t2_setup_paddr", 64'(paddr), 64'd8);

    // 3. Unaligned redirect while idle and full.
    tick(4);
    check_eq("t3_count_full", 64'(count), 64'd8);
    check_eq("t3_psel_idle", 64'(psel), 64'd0);
    redirect = 1'b1; redirect_pc = 32'd5;
    tick(1);
    redirect = 1'b0;
    check_eq("t3_count_flush", 64'(count), 64'd0);
    check_eq("t3_valid_flush", 64'(inst_valid), 64'd0);
    wait_for("t3_wait_setup", 0, 4);
    check_eq("t3_paddr", 64'(paddr), 64'd4);
    wait_for("t3_wait_valid", 2, 6);
    check_eq("t3_head_pc", 64'(inst_pc), 64'd5);
    check_eq("t3_head_inst", 64'(inst), 64'h1005);
    check_eq("t3_count_first", 64'(count), 64'd1);
    tick(10);
    check_eq("t3_count_settled", 64'(count), 64'd7);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    check_eq("t3_next_pc", 64'(inst_pc), 64'd6);
    check_eq("t3_next_inst", 64'(inst), 64'h1006);

    // 4. Redirect during a slow ACCESS; the returned word must be dropped.
    ready_delay = 3;
    do_reset();
    xbase = n_xfers;
    wait_for("t4_wait_access", 1, 5);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick(1);
    redirect = 1'b0;
    check_eq("t4_still_access", 64'({psel, penable}), 64'd3);
    wait_for("t4_wait_setup", 0, 10);
    check_eq("t4_paddr", 64'(paddr), 64'h40);
    check_eq("t4_count_zero", 64'(count), 64'd0);
    check_eq("t4_valid_zero", 64'(inst_valid), 64'd0);
    check_eq("t4_one_xfer", 64'(n_xfers - xbase), 64'd1);
    wait_for("t4_wait_valid", 2, 12);
    check_eq("t4_head_pc", 64'(inst_pc), 64'h40);
    check_eq("t4_head_inst", 64'(inst), 64'h1040);
    ready_delay = 0;

    // 5. Push and pop in the same cycle, then redirect colliding with pready.
    do_reset();
    tick(14);
    check_eq("t5_count_full", 64'(count), 64'd8);
    manual_mode = 1'b1; ready_man = 1'b0;
    stall = 1'b0;
    tick(2);
    stall = 1'b1;
    wait_for("t5_wait_access", 1, 6);
    check_eq("t5_count_pre", 64'(count), 64'd6);
    stall = 1'b0; ready_man = 1'b1;
    tick(1);
    stall = 1'b1; ready_man = 1'b0;
    check_eq("t5_count_pushpop", 64'(count), 64'd7);
    check_eq("t5_head_pc", 64'(inst_pc), 64'd3);
    check_eq("t5_head_inst", 64'(inst), 64'h1003);
    tick(1);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    wait_for("t5_wait_access2", 1, 6);
    check_eq("t5_count_pre2", 64'(count), 64'd6);
    stall = 1'b0; ready_man = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    tick(1);
    stall = 1'b1; ready_man = 1'b0; redirect = 1'b0;
    check_eq("t5_redir_count", 64'(count), 64'd0);
    check_eq("t5_redir_valid", 64'(inst_valid), 64'd0);
    wait_for("t5_wait_setup", 0, 4);
    check_eq("t5_redir_paddr", 64'(paddr), 64'h100);
    ready_man = 1'b1;
    wait_for("t5_wait_valid", 2, 8);
    check_eq("t5_redir_head_pc", 64'(inst_pc), 64'h100);
    check_eq("t5_redir_count2", 64'(count), 64'd2);
    manual_mode = 1'b0; ready_man = 1'b0;

    // 6. Address wrap-around.
    rst = 1'b0;
    tick(2);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    sbase = setup_addrs.size();
    tick(1);
    redirect = 1'b0;
    tick(14);
    check_eq("t6_paddr_seq0", 64'(setup_at(sbase)), 64'hFFFF_FFFE);
    check_eq("t6_paddr_seq1", 64'(setup_at(sbase + 1)), 64'h0);
    check_eq("t6_count_full", 64'(count), 64'd8);
    check_eq("t6_head_pc", 64'(inst_pc), 64'hFFFF_FFFE);
    check_eq("t6_head_inst", 64'(inst), 64'h0FFE);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    check_eq("t6_pc_ffff", 64'(inst_pc), 64'hFFFF_FFFF);
    check_eq("t6_inst_ffff", 64'(inst), 64'h0FFF);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    check_eq("t6_pc_wrap", 64'(inst_pc), 64'h0);
    check_eq("t6_inst_wrap", 64'(inst), 64'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
